split_join_sched: RTL and testbench

- Front-end scheduler for the per-warp split/join (IPDOM) unit.
- Arbitrates divergence requests (split/join) from NUM_REQS issue-side requesters round-robin, forwarding at most one per cycle through a registered output.
- Blocks a warp while its join result is in flight.
- Tracks per-warp reconvergence stack depth to suppress and flag overflow/underflow before they corrupt the stack.

---
 rtl/split_join_sched_pkg.sv | 32 +++
 rtl/split_join_sched_if.sv | 33 +++
 rtl/split_join_sched_arb.sv | 45 ++++
 rtl/split_join_sched.sv | 143 ++++++++++++++
 tb/tb_split_join_sched.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/split_join_sched_pkg.sv
// Shared types for the split/join front-end scheduler: divergence descriptors,
// error codes and the width helper used for warp/requester indices.
package split_join_sched_pkg;

  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int STACK_PTR_W = 2;

  localparam logic [1:0] SJ_ERR_NONE = 2'b00;
  localparam logic [1:0] SJ_ERR_OVF  = 2'b01;
  localparam logic [1:0] SJ_ERR_UNF  = 2'b10;
  localparam logic [1:0] SJ_ERR_ILL  = 2'b11;

  typedef struct packed {
    logic                   valid;
    logic                   is_dvg;
    logic [NUM_THREADS-1:0] then_tmask;
    logic [NUM_THREADS-1:0] else_tmask;
    logic [31:0]            next_pc;
  } split_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_dvg;
    logic [STACK_PTR_W-1:0] stack_ptr;
  } join_t;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/split_join_sched_if.sv
// Request, forward and join-response bundle between issue slices, the scheduler
// and the IPDOM stack unit.
interface split_join_sched_if #(
  parameter int NUM_REQS = 2,
  parameter int WID_W    = 2
);
  import split_join_sched_pkg::*;

  logic [NUM_REQS-1:0]            req_valid;
  logic [NUM_REQS-1:0][WID_W-1:0] req_wid;
  split_t [NUM_REQS-1:0]          req_split;
  join_t  [NUM_REQS-1:0]          req_join;
  logic [NUM_REQS-1:0]            req_ready;

  logic                           sj_valid;
  logic [WID_W-1:0]               sj_wid;
  split_t                         sj_split;
  join_t                          sj_join;

  logic                           join_rsp_valid;
  logic [WID_W-1:0]               join_rsp_wid;

  modport master (
    output req_valid, req_wid, req_split, req_join, join_rsp_valid, join_rsp_wid,
    input  req_ready, sj_valid, sj_wid, sj_split, sj_join
  );

  modport slave (
    input  req_valid, req_wid, req_split, req_join, join_rsp_valid, join_rsp_wid,
    output req_ready, sj_valid, sj_wid, sj_split, sj_join
  );

endinterface

// File: rtl/split_join_sched_arb.sv
// Round-robin arbiter without lock: scans upward from the pointer, wrapping,
// and moves the pointer one past the winner whenever a grant is issued.
module split_join_sched_arb #(
  parameter int NUM_REQS = 2,
  parameter int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [IDX_W-1:0]    grant_index,
  output logic                grant_valid
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   scan_sum;
  logic [IDX_W-1:0] scan_idx;

  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    scan_sum     = '0;
    scan_idx     = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      scan_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(NUM_REQS))
        scan_sum = scan_sum - (IDX_W+1)'(NUM_REQS);
      scan_idx = scan_sum[IDX_W-1:0];
      if (!grant_valid && requests[scan_idx]) begin
        grant_valid            = 1'b1;
        grant_index            = scan_idx;
        grant_onehot[scan_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr_q <= '0;
    else if (grant_valid)
      ptr_q <= (grant_index == IDX_W'(NUM_REQS-1)) ? '0 : grant_index + IDX_W'(1);
  end

endmodule

// File: rtl/split_join_sched.sv
// Split/join front-end: picks one eligible divergence request per cycle, guards
// per-warp IPDOM depth, blocks warps with a join in flight and latches the first error.
module split_join_sched
  import split_join_sched_pkg::*;
#(
  parameter int NUM_REQS       = 2,
  parameter int WARP_CNT       = NUM_WARPS,
  parameter int THREAD_CNT     = NUM_THREADS,
  parameter int WARP_CNT_WIDTH = log2up(WARP_CNT),
  parameter int STACK_DEPTH    = (THREAD_CNT > 1) ? (THREAD_CNT - 1) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  split_join_sched_if.slave         sj_if,
  output logic [WARP_CNT-1:0]       warp_busy,
  output logic                      err_valid,
  output logic [1:0]                err_code,
  output logic [WARP_CNT_WIDTH-1:0] err_wid
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = log2up(NUM_REQS);

  logic [WARP_CNT-1:0]       busy_q;
  logic [WARP_CNT-1:0]       clr_mask;
  logic [WARP_CNT-1:0]       set_mask;
  logic [NUM_REQS-1:0]       eligible;
  logic [NUM_REQS-1:0]       grant_oh;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_valid;

  logic [DEPTH_W-1:0]        depth_q [WARP_CNT];
  logic [DEPTH_W-1:0]        cur_depth;
  logic [WARP_CNT_WIDTH-1:0] sel_wid;
  split_t                    fwd_split;
  join_t                     fwd_join;
  logic                      do_push;
  logic                      do_pop;
  logic                      err_hit;
  logic [1:0]                err_c;

  // A response on the same cycle unblocks its warp; reset masks all requests.
  always_comb begin
    clr_mask = '0;
    if (sj_if.join_rsp_valid)
      clr_mask[sj_if.join_rsp_wid] = 1'b1;
    for (int i = 0; i < NUM_REQS; i++)
      eligible[i] = reset && sj_if.req_valid[i] &&
                    !(busy_q[sj_if.req_wid[i]] && !clr_mask[sj_if.req_wid[i]]);
  end

  split_join_sched_arb #(.NUM_REQS(NUM_REQS), .IDX_W(IDX_W)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (eligible),
    .grant_onehot (grant_oh),
    .grant_index  (grant_idx),
    .grant_valid  (grant_valid)
  );

  assign sj_if.req_ready = grant_oh;

  always_comb begin
    sel_wid   = sj_if.req_wid[grant_idx];
    fwd_split = sj_if.req_split[grant_idx];
    fwd_join  = sj_if.req_join[grant_idx];
    cur_depth = depth_q[sel_wid];
    err_hit   = 1'b0;
    err_c     = SJ_ERR_NONE;
    set_mask  = '0;

    if (fwd_split.valid && fwd_join.valid) begin
      fwd_join.valid = 1'b0;
      err_hit        = 1'b1;
      err_c          = SJ_ERR_ILL;
    end
    if (fwd_split.valid && fwd_split.is_dvg && cur_depth == DEPTH_W'(STACK_DEPTH)) begin
      fwd_split.valid = 1'b0;
      if (!err_hit) err_c = SJ_ERR_OVF;
      err_hit = 1'b1;
    end
    if (fwd_join.valid && fwd_join.is_dvg && cur_depth == '0) begin
      fwd_join.valid = 1'b0;
      err_hit        = 1'b1;
      err_c          = SJ_ERR_UNF;
    end

    do_push = grant_valid && fwd_split.valid && fwd_split.is_dvg;
    do_pop  = grant_valid && fwd_join.valid && fwd_join.is_dvg;
    if (grant_valid && fwd_join.valid)
      set_mask[sel_wid] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sj_if.sj_valid <= 1'b0;
      sj_if.sj_wid   <= '0;
      sj_if.sj_split <= '0;
      sj_if.sj_join  <= '0;
    end else begin
      sj_if.sj_valid <= grant_valid;
      if (grant_valid) begin
        sj_if.sj_wid   <= sel_wid;
        sj_if.sj_split <= fwd_split;
        sj_if.sj_join  <= fwd_join;
      end
    end
  end

  // Set has priority over clear so a join re-issued on its response cycle stays blocked.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      busy_q <= '0;
    else
      busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WARP_CNT; w++)
        depth_q[w] <= '0;
    end else if (do_push) begin
      depth_q[sel_wid] <= cur_depth + DEPTH_W'(1);
    end else if (do_pop) begin
      depth_q[sel_wid] <= cur_depth - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_valid <= 1'b0;
      err_code  <= SJ_ERR_NONE;
      err_wid   <= '0;
    end else if (grant_valid && err_hit && !err_valid) begin
      err_valid <= 1'b1;
      err_code  <= err_c;
      err_wid   <= sel_wid;
    end
  end

  assign warp_busy = busy_q;

endmodule

// File: tb/tb_split_join_sched.sv
// Bench for split_join_sched: per-cycle vector table with a forward-path
// scoreboard, plus hand sequences for reset during operation.
module tb_split_join_sched;
  import split_join_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  split_join_sched_if #(.NUM_REQS(2), .WID_W(2)) bus ();

  logic [3:0] warp_busy;
  logic       err_valid;
  logic [1:0] err_code;
  logic [1:0] err_wid;

  split_join_sched #(.NUM_REQS(2), .WARP_CNT(4), .THREAD_CNT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sj_if     (bus.slave),
    .warp_busy (warp_busy),
    .err_valid (err_valid),
    .err_code  (err_code),
    .err_wid   (err_wid)
  );

  typedef struct {
    logic [1:0] vld;
    logic [1:0] w0, w1;
    logic [1:0] s0, j0, s1, j1;   // {valid, is_dvg}
    logic       rv;
    logic [1:0] rw;
    logic [1:0] e_rdy;
    logic       e_sv, e_jv;
    logic [1:0] e_wid;
    logic [3:0] e_busy;
    logic [2:0] e_err;            // {err_valid, err_code}
    logic [1:0] e_ewid;
  } vec_t;

  typedef struct {
    logic [1:0]  wid;
    logic        sv;
    logic        jv;
    logic [31:0] pc;
  } exp_t;

  localparam logic [1:0] NO = 2'b00, DV = 2'b11, ND = 2'b10;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic [1:0] vld, w0, w1, s0, j0, s1, j1,
    input logic rv, input logic [1:0] rw,
    input logic [1:0] e_rdy, input logic e_sv, e_jv, input logic [1:0] e_wid,
    input logic [3:0] e_busy, input logic [2:0] e_err, input logic [1:0] e_ewid);
    vec_t v;
    v.vld = vld; v.w0 = w0; v.w1 = w1; v.s0 = s0; v.j0 = j0; v.s1 = s1; v.j1 = j1;
    v.rv = rv; v.rw = rw; v.e_rdy = e_rdy; v.e_sv = e_sv; v.e_jv = e_jv;
    v.e_wid = e_wid; v.e_busy = e_busy; v.e_err = e_err; v.e_ewid = e_ewid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] pc_of(input int port, input int n);
    return (port == 1 ? 32'h2000_0000 : 32'h1000_0000) + 32'(n * 16);
  endfunction

  task automatic drive(input vec_t v, input int n);
    split_t sp;
    join_t  jn;
    bus.req_valid  = v.vld;
    bus.req_wid[0] = v.w0;
    bus.req_wid[1] = v.w1;
    sp = '{valid: v.s0[1], is_dvg: v.s0[0], then_tmask: 4'h3, else_tmask: 4'hC, next_pc: pc_of(0, n)};
    bus.req_split[0] = sp;
    sp = '{valid: v.s1[1], is_dvg: v.s1[0], then_tmask: 4'h5, else_tmask: 4'hA, next_pc: pc_of(1, n)};
    bus.req_split[1] = sp;
    jn = '{valid: v.j0[1], is_dvg: v.j0[0], stack_ptr: 2'd1};
    bus.req_join[0] = jn;
    jn = '{valid: v.j1[1], is_dvg: v.j1[0], stack_ptr: 2'd2};
    bus.req_join[1] = jn;
    bus.join_rsp_valid = v.rv;
    bus.join_rsp_wid   = v.rw;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_wid = '0; bus.req_split = '0; bus.req_join = '0;
    bus.join_rsp_valid = 1'b0; bus.join_rsp_wid = '0;
  endtask

  task automatic apply(input vec_t v, input int n);
    exp_t e;
    @(negedge clk);
    drive(v, n);
    #1;
    chk($sformatf("v%0d req_ready", n), 32'(bus.req_ready), 32'(v.e_rdy));
    if (v.e_rdy != 2'b00) begin
      e.wid = v.e_wid; e.sv = v.e_sv; e.jv = v.e_jv;
      e.pc  = pc_of(v.e_rdy[1] ? 1 : 0, n);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("v%0d sj_valid", n), 32'(bus.sj_valid), 32'd1);
      chk($sformatf("v%0d sj_wid", n), 32'(bus.sj_wid), 32'(e.wid));
      chk($sformatf("v%0d sj_split.valid", n), 32'(bus.sj_split.valid), 32'(e.sv));
      chk($sformatf("v%0d sj_join.valid", n), 32'(bus.sj_join.valid), 32'(e.jv));
      chk($sformatf("v%0d sj_split.next_pc", n), bus.sj_split.next_pc, e.pc);
    end else begin
      chk($sformatf("v%0d sj_valid idle", n), 32'(bus.sj_valid), 32'd0);
    end
    chk($sformatf("v%0d warp_busy", n), 32'(warp_busy), 32'(v.e_busy));
    chk($sformatf("v%0d err", n), 32'({err_valid, err_code}), 32'(v.e_err));
    chk($sformatf("v%0d err_wid", n), 32'(err_wid), 32'(v.e_ewid));
  endtask

  initial begin
    //                 vld   w0 w1 s0  j0  s1  j1  rv rw  rdy   sv jv wid busy     err     ewid
    tbl_a.push_back(mk(2'b11, 1, 2, DV, NO, DV, NO, 0, 0, 2'b01, 1, 0, 1, 4'b0000, 3'b000, 0));
    tbl_a.push_back(mk(2'b11, 1, 2, DV, NO, DV, NO, 0, 0, 2'b10, 1, 0, 2, 4'b0000, 3'b000, 0));
    tbl_a.push_back(mk(2'b11, 1, 2, DV, NO, DV, NO, 0, 0, 2'b01, 1, 0, 1, 4'b0000, 3'b000, 0));
    tbl_a.push_back(mk(2'b11, 1, 2, DV, NO, DV, NO, 0, 0, 2'b10, 1, 0, 2, 4'b0000, 3'b000, 0));
    tbl_a.push_back(mk(2'b11, 3, 0, NO, ND, DV, NO, 0, 0, 2'b01, 0, 1, 3, 4'b1000, 3'b000, 0));
    tbl_a.push_back(mk(2'b11, 3, 0, NO, ND, DV, NO, 0, 0, 2'b10, 1, 0, 0, 4'b1000, 3'b000, 0));
    tbl_a.push_back(mk(2'b01, 3, 0, NO, ND, NO, NO, 1, 3, 2'b01, 0, 1, 3, 4'b1000, 3'b000, 0));
    tbl_a.push_back(mk(2'b00, 0, 0, NO, NO, NO, NO, 1, 3, 2'b00, 0, 0, 0, 4'b0000, 3'b000, 0));
    tbl_a.push_back(mk(2'b10, 0, 2, NO, NO, DV, NO, 1, 2, 2'b10, 1, 0, 2, 4'b0000, 3'b000, 0));
    tbl_a.push_back(mk(2'b11, 1, 1, ND, NO, ND, NO, 0, 0, 2'b01, 1, 0, 1, 4'b0000, 3'b000, 0));
    tbl_a.push_back(mk(2'b11, 1, 1, ND, NO, ND, NO, 0, 0, 2'b10, 1, 0, 1, 4'b0000, 3'b000, 0));
    tbl_a.push_back(mk(2'b01, 3, 0, NO, DV, NO, NO, 0, 0, 2'b01, 0, 0, 3, 4'b0000, 3'b110, 3));
    tbl_a.push_back(mk(2'b10, 0, 2, NO, NO, DV, NO, 0, 0, 2'b10, 0, 0, 2, 4'b0000, 3'b110, 3));
    tbl_a.push_back(mk(2'b01, 1, 0, DV, DV, NO, NO, 0, 0, 2'b01, 1, 0, 1, 4'b0000, 3'b110, 3));
    tbl_a.push_back(mk(2'b10, 0, 1, NO, NO, NO, DV, 0, 0, 2'b10, 0, 1, 1, 4'b0010, 3'b110, 3));
    tbl_a.push_back(mk(2'b00, 0, 0, NO, NO, NO, NO, 1, 1, 2'b00, 0, 0, 0, 4'b0000, 3'b110, 3));
    tbl_a.push_back(mk(2'b01, 2, 0, NO, DV, NO, NO, 0, 0, 2'b01, 0, 1, 2, 4'b0100, 3'b110, 3));
    tbl_a.push_back(mk(2'b01, 3, 0, NO, ND, NO, NO, 1, 2, 2'b01, 0, 1, 3, 4'b1000, 3'b110, 3));

    tbl_b.push_back(mk(2'b11, 1, 2, ND, NO, ND, NO, 0, 0, 2'b01, 1, 0, 1, 4'b0000, 3'b000, 0));
    tbl_b.push_back(mk(2'b01, 0, 0, DV, NO, NO, NO, 0, 0, 2'b01, 1, 0, 0, 4'b0000, 3'b000, 0));
    tbl_b.push_back(mk(2'b01, 0, 0, DV, NO, NO, NO, 0, 0, 2'b01, 1, 0, 0, 4'b0000, 3'b000, 0));
    tbl_b.push_back(mk(2'b01, 0, 0, DV, NO, NO, NO, 0, 0, 2'b01, 1, 0, 0, 4'b0000, 3'b000, 0));
    tbl_b.push_back(mk(2'b01, 0, 0, DV, NO, NO, NO, 0, 0, 2'b01, 0, 0, 0, 4'b0000, 3'b101, 0));
    tbl_b.push_back(mk(2'b01, 0, 0, NO, DV, NO, NO, 0, 0, 2'b01, 0, 1, 0, 4'b0001, 3'b101, 0));
    tbl_b.push_back(mk(2'b10, 0, 3, NO, NO, NO, DV, 1, 0, 2'b10, 0, 0, 3, 4'b0000, 3'b101, 0));
    tbl_b.push_back(mk(2'b11, 2, 2, ND, NO, DV, NO, 0, 0, 2'b01, 1, 0, 2, 4'b0000, 3'b101, 0));
    tbl_b.push_back(mk(2'b11, 2, 2, ND, NO, DV, NO, 0, 0, 2'b10, 1, 0, 2, 4'b0000, 3'b101, 0));

    // Held in reset with both requesters asserting: nothing may be accepted.
    reset = 1'b0;
    idle_inputs();
    bus.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst sj_valid", 32'(bus.sj_valid), 32'd0);
    chk("rst warp_busy", 32'(warp_busy), 32'd0);
    chk("rst err_valid", 32'(err_valid), 32'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;

    for (int n = 0; n < tbl_a.size(); n++)
      apply(tbl_a[n], n);

    // Asynchronous reset between edges while warp 3 is busy and depths are nonzero.
    #2;
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("async warp_busy", 32'(warp_busy), 32'd0);
    chk("async sj_valid", 32'(bus.sj_valid), 32'd0);
    chk("async sj_wid", 32'(bus.sj_wid), 32'd0);
    chk("async err", 32'({err_valid, err_code}), 32'd0);
    chk("async err_wid", 32'(err_wid), 32'd0);
    chk("async req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();

    for (int n = 0; n < tbl_b.size(); n++)
      apply(tbl_b[n], 100 + n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
